// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: shares one combinational ALU between two requesters.
// Round-robin arbitration in IDLE, one evaluation cycle in EXEC, and the
// captured result/flags are held in RESP until the consumer takes them.
module alu_rr_scheduler #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_opcode,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [SHW-1:0]   req0_shift,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_opcode,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [SHW-1:0]   req1_shift,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,

  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [SHW-1:0]   alu_shiftValue,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryFlag,
  input  logic             alu_zeroFlag,
  input  logic             alu_overFlowFlag,
  input  logic             alu_signFlag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shift;
    logic             id;
    logic             err;
  } cmd_t;

  state_t state;
  logic   prio;
  logic   cmd_id;
  logic   cmd_err;
  logic   grant0;
  logic   grant1;
  cmd_t   sel_cmd;

  // Round-robin grant: the requester at prio wins when valid, else the other.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      grant0 = req0_valid && (!prio || !req1_valid);
      grant1 = req1_valid && ( prio || !req0_valid);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Mux the winning requester's command fields.
  always_comb begin
    sel_cmd.opcode = req0_opcode;
    sel_cmd.a      = req0_a;
    sel_cmd.b      = req0_b;
    sel_cmd.shift  = req0_shift;
    sel_cmd.id     = 1'b0;
    if (grant1) begin
      sel_cmd.opcode = req1_opcode;
      sel_cmd.a      = req1_a;
      sel_cmd.b      = req1_b;
      sel_cmd.shift  = req1_shift;
      sel_cmd.id     = 1'b1;
    end
    sel_cmd.err = sel_cmd.opcode[3];
  end

  // Sequencer: the alu_* registers double as the command register, so they
  // read zero in IDLE and hold the command through EXEC and RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      prio           <= 1'b0;
      cmd_id         <= 1'b0;
      cmd_err        <= 1'b0;
      alu_opcode     <= 4'd0;
      alu_input1     <= WIDTH'(0);
      alu_input2     <= WIDTH'(0);
      alu_shiftValue <= SHW'(0);
      rsp_valid      <= 1'b0;
      rsp_id         <= 1'b0;
      rsp_result     <= WIDTH'(0);
      rsp_flags      <= 4'd0;
      rsp_err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            cmd_id         <= sel_cmd.id;
            cmd_err        <= sel_cmd.err;
            prio           <= ~sel_cmd.id;
            alu_opcode     <= sel_cmd.err ? 4'd0 : sel_cmd.opcode;
            alu_input1     <= sel_cmd.a;
            alu_input2     <= sel_cmd.b;
            alu_shiftValue <= sel_cmd.shift;
            state          <= EXEC;
          end
        end
        EXEC: begin
          rsp_valid <= 1'b1;
          rsp_id    <= cmd_id;
          rsp_err   <= cmd_err;
          if (cmd_err) begin
            rsp_result <= WIDTH'(0);
            rsp_flags  <= 4'd0;
          end else begin
            rsp_result <= alu_result;
            rsp_flags  <= {alu_carryFlag, alu_zeroFlag, alu_overFlowFlag, alu_signFlag};
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid      <= 1'b0;
            alu_opcode     <= 4'd0;
            alu_input1     <= WIDTH'(0);
            alu_input2     <= WIDTH'(0);
            alu_shiftValue <= SHW'(0);
            state          <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Testbench for alu_rr_scheduler: bench-side ALU stub, cycle model of the
// sequencer/arbiter, and a scoreboard of expected responses.
module tb_alu_rr_scheduler;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned SHW   = 5;
  localparam int M_IDLE = 0;
  localparam int M_EXEC = 1;
  localparam int M_RESP = 2;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_opcode, req1_opcode;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [SHW-1:0] req0_shift, req1_shift;
  logic rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0] rsp_flags;
  logic [3:0] alu_opcode;
  logic [WIDTH-1:0] alu_input1, alu_input2, alu_result;
  logic [SHW-1:0] alu_shiftValue;
  logic alu_carryFlag, alu_zeroFlag, alu_overFlowFlag, alu_signFlag;

  typedef struct {
    logic       id;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] sh;
    logic [7:0] res;
    logic [3:0] flags;
    logic       err;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mst = M_IDLE;
  logic mprio = 1'b0;
  int rsp_cnt = 0;
  int last_acc = -1;
  bit spacing_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_rr_scheduler #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b), .req0_shift(req0_shift),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b), .req1_shift(req1_shift),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_shiftValue(alu_shiftValue), .alu_result(alu_result),
    .alu_carryFlag(alu_carryFlag), .alu_zeroFlag(alu_zeroFlag),
    .alu_overFlowFlag(alu_overFlowFlag), .alu_signFlag(alu_signFlag)
  );

  // Reference ALU: returns {result, carry, zero, overflow, sign}.
  function automatic logic [11:0] alu_ref(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [4:0] sh);
    logic [15:0] t;
    logic [8:0]  s;
    logic [7:0]  r;
    logic        c;
    logic        o;
    c = 1'b0;
    o = 1'b0;
    r = 8'h00;
    case (op)
      4'd0: begin t = {a, a} << sh[2:0]; r = t[15:8]; end
      4'd1: begin t = {a, a} >> sh[2:0]; r = t[7:0]; end
      4'd2: r = (a > b) ? a : b;
      4'd3: r = (a < b) ? a : b;
      4'd4: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8];
                  o = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd5: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8];
                  o = (a[7] != b[7]) && (r[7] != a[7]); end
      4'd6: r = a | b;
      4'd7: r = a & b;
      default: begin r = a ^ b; c = 1'b1; o = 1'b1; end
    endcase
    return {r, c, (r == 8'h00), o, r[7]};
  endfunction

  // ALU stub driven by the DUT's alu_* outputs.
  always_comb begin
    {alu_result, alu_carryFlag, alu_zeroFlag, alu_overFlowFlag, alu_signFlag} =
      alu_ref(alu_opcode, alu_input1, alu_input2, alu_shiftValue);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t make_exp(input logic id, input logic [3:0] op, input logic [7:0] a,
                                    input logic [7:0] b, input logic [4:0] sh);
    exp_t e;
    logic [11:0] v;
    e.id = id; e.op = op; e.a = a; e.b = b; e.sh = sh;
    e.err = op[3];
    v = e.err ? 12'h000 : alu_ref(op, a, b, sh);
    e.res = v[11:4];
    e.flags = v[3:0];
    return e;
  endfunction

  // Cycle model sampled mid-cycle: checks readies, alu_* and rsp_* and
  // steps the expected state/prio; the scoreboard tracks the in-flight command.
  always @(negedge clk) begin
    logic er0, er1;
    exp_t e;
    if (rst) begin
      sbq.delete();
      mst = M_IDLE;
      mprio = 1'b0;
    end else begin
      er0 = (mst == M_IDLE) && req0_valid && (!mprio || !req1_valid);
      er1 = (mst == M_IDLE) && req1_valid && ( mprio || !req0_valid);
      check("req0_ready", 32'(req0_ready), 32'(er0));
      check("req1_ready", 32'(req1_ready), 32'(er1));
      check("rsp_valid", 32'(rsp_valid), 32'(mst == M_RESP));
      if (mst == M_IDLE) begin
        check("alu_opcode_idle", 32'(alu_opcode), 32'd0);
        check("alu_in1_idle", 32'(alu_input1), 32'd0);
        check("alu_in2_idle", 32'(alu_input2), 32'd0);
        check("alu_sh_idle", 32'(alu_shiftValue), 32'd0);
      end else if (sbq.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sbq[0];
        check("alu_opcode", 32'(alu_opcode), 32'(e.err ? 4'd0 : e.op));
        check("alu_in1", 32'(alu_input1), 32'(e.a));
        check("alu_in2", 32'(alu_input2), 32'(e.b));
        check("alu_sh", 32'(alu_shiftValue), 32'(e.sh));
        if (mst == M_RESP) begin
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_result", 32'(rsp_result), 32'(e.res));
          check("rsp_flags", 32'(rsp_flags), 32'(e.flags));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
      case (mst)
        M_IDLE: begin
          if (er0 || er1) begin
            if (er1) sbq.push_back(make_exp(1'b1, req1_opcode, req1_a, req1_b, req1_shift));
            else     sbq.push_back(make_exp(1'b0, req0_opcode, req0_a, req0_b, req0_shift));
            mprio = er0;
            if (spacing_on && last_acc >= 0) check("accept_spacing", 32'(cyc - last_acc), 32'd3);
            last_acc = cyc;
            mst = M_EXEC;
          end
        end
        M_EXEC: mst = M_RESP;
        default: begin
          if (rsp_ready) begin
            if (sbq.size() > 0) void'(sbq.pop_front());
            rsp_cnt++;
            mst = M_IDLE;
          end
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic id, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [4:0] sh);
    if (id) begin
      req1_opcode = op; req1_a = a; req1_b = b; req1_shift = sh; req1_valid = 1'b1;
    end else begin
      req0_opcode = op; req0_a = a; req0_b = b; req0_shift = sh; req0_valid = 1'b1;
    end
  endtask

  // Present one command and hold valid until it is accepted.
  task automatic send(input logic id, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [4:0] sh);
    bit done;
    done = 1'b0;
    set_req(id, op, a, b, sh);
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      #1;
      done = id ? req1_ready : req0_ready;
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      #1;
      done = (mst == M_IDLE) && (sbq.size() == 0);
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    check({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
    check({tag, "_rsp_flags"}, 32'(rsp_flags), 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_alu_opcode"}, 32'(alu_opcode), 32'd0);
    check({tag, "_alu_in1"}, 32'(alu_input1), 32'd0);
    check({tag, "_alu_in2"}, 32'(alu_input2), 32'd0);
    check({tag, "_alu_sh"}, 32'(alu_shiftValue), 32'd0);
  endtask

  // Both requesters valid; expect req0 to take the grant, then withdraw.
  task automatic both_expect_req0(input string tag);
    bit done;
    done = 1'b0;
    set_req(1'b0, 4'd5, 8'h10, 8'h20, 5'd0);
    set_req(1'b1, 4'd6, 8'h0F, 8'hA0, 5'd0);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      #1;
      done = req0_ready || req1_ready;
    end
    check(tag, 32'({req1_ready, req0_ready}), 32'b01);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    int target;
    bit done;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    req0_opcode = 4'd0; req0_a = 8'h00; req0_b = 8'h00; req0_shift = 5'd0;
    req1_opcode = 4'd0; req1_a = 8'h00; req1_b = 8'h00; req1_shift = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("reset");

    // ADD 0x7F + 0x01 from req0.
    send(1'b0, 4'd4, 8'h7F, 8'h01, 5'd0);
    wait_idle();

    // Both requesters continuously valid with ROL: alternate, 3-cycle spacing.
    set_req(1'b0, 4'd0, 8'h81, 8'h00, 5'd1);
    set_req(1'b1, 4'd0, 8'h81, 8'h00, 5'd1);
    spacing_on = 1'b1;
    last_acc = -1;
    target = rsp_cnt + 6;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      #1;
      done = rsp_cnt >= target;
    end
    if (!done) check("alternate_timeout", 32'd0, 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    spacing_on = 1'b0;
    wait_idle();

    // req1 MAX with backpressure; req0 raises then withdraws valid meanwhile.
    rsp_ready = 1'b0;
    send(1'b1, 4'd2, 8'h10, 8'h20, 5'd0);
    tick();
    check("bp_in_resp", 32'(mst), 32'(M_RESP));
    set_req(1'b0, 4'd4, 8'h01, 8'h02, 5'd0);
    repeat (2) tick();
    req0_valid = 1'b0;
    repeat (2) tick();
    rsp_ready = 1'b1;
    wait_idle();
    both_expect_req0("prio_after_drop");

    // Illegal opcode from req0.
    send(1'b0, 4'd9, 8'h55, 8'hAA, 5'd3);
    wait_idle();

    // Reset while req1 AND is in EXEC: command dropped, prio back to req0.
    send(1'b1, 4'd7, 8'hF0, 8'h3C, 5'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midrst");
    repeat (5) tick();
    check("midrst_quiet", 32'(rsp_valid), 32'd0);
    both_expect_req0("prio_after_rst");

    // Random legal/illegal commands from either side.
    for (int i = 0; i < 12; i++) begin
      send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 8'($urandom),
           8'($urandom), 5'($urandom));
      wait_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
